// File: rtl/spi_reg_bank.sv
// Register bank behind the SPI register bus: clock master control, per-channel dividers,
// sticky status, a saturating write counter and one-cycle update strobes.
// Optional feature macro: SPI_REG_BANK_LOCK_EN adds a two-key write-lock FSM that guards CTRL
// and DIVn writes; without it those registers are always writable and KEY reads 0x00.
module spi_reg_bank #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned N_CH       = 4,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = 8'hC1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [ADDR_WIDTH-1:0]      i_addr_bus,
  input  logic [DATA_WIDTH-1:0]      i_data_write_bus,
  input  logic                       i_wr_enable_bus,
  output logic [DATA_WIDTH-1:0]      o_data_read_bus,
  input  logic [DATA_WIDTH-1:0]      i_status_evt,
  output logic [DATA_WIDTH-1:0]      o_ctrl,
  output logic [DATA_WIDTH-1:0]      o_strobe,
  output logic [N_CH*DATA_WIDTH-1:0] o_div,
  output logic [N_CH-1:0]            o_div_update
);

  localparam logic [ADDR_WIDTH-1:0] AddrId      = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] AddrCtrl    = ADDR_WIDTH'(8'h01);
  localparam logic [ADDR_WIDTH-1:0] AddrStrobe  = ADDR_WIDTH'(8'h02);
  localparam logic [ADDR_WIDTH-1:0] AddrStatus  = ADDR_WIDTH'(8'h03);
  localparam int unsigned           AddrDivBase = 4;
  localparam logic [ADDR_WIDTH-1:0] AddrWrCount = ADDR_WIDTH'(8'h10);
  localparam logic [ADDR_WIDTH-1:0] AddrKey     = ADDR_WIDTH'(8'h11);

  logic                  wr_en_q;
  logic                  accept;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] status_q;
  logic [DATA_WIDTH-1:0] status_clr;
  logic [DATA_WIDTH-1:0] wr_count_q;
  logic [DATA_WIDTH-1:0] key_rdata;
  logic [DATA_WIDTH-1:0] rdata;

  // A held-high enable only counts once: accept on its rising edge.
  assign accept     = i_wr_enable_bus & ~wr_en_q;
  assign status_clr = (accept && i_addr_bus == AddrStatus) ? i_data_write_bus : '0;

`ifdef SPI_REG_BANK_LOCK_EN
  typedef enum logic [1:0] {
    StLocked   = 2'd0,
    StKey1     = 2'd1,
    StUnlocked = 2'd2
  } lock_state_e;

  lock_state_e lock_q;

  // Lock FSM: 0xA5 then 0x5A to KEY unlocks; any KEY write while unlocked relocks.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      lock_q <= StLocked;
    end else if (accept) begin
      case (lock_q)
        StLocked: begin
          if (i_addr_bus == AddrKey && i_data_write_bus == DATA_WIDTH'(8'hA5)) lock_q <= StKey1;
        end
        StKey1: begin
          if (i_addr_bus == AddrKey && i_data_write_bus == DATA_WIDTH'(8'h5A)) begin
            lock_q <= StUnlocked;
          end else begin
            lock_q <= StLocked;
          end
        end
        StUnlocked: begin
          if (i_addr_bus == AddrKey) lock_q <= StLocked;
        end
        default: lock_q <= StLocked;
      endcase
    end
  end

  assign wr_ok     = (lock_q == StUnlocked);
  assign key_rdata = {{(DATA_WIDTH-2){1'b0}}, lock_q};
`else
  assign wr_ok     = 1'b1;
  assign key_rdata = '0;
`endif

  // Register state: write decode, strobes, sticky status and saturating write counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_en_q      <= 1'b0;
      o_ctrl       <= '0;
      o_strobe     <= '0;
      o_div        <= '0;
      o_div_update <= '0;
      status_q     <= '0;
      wr_count_q   <= '0;
    end else begin
      wr_en_q      <= i_wr_enable_bus;
      o_strobe     <= '0;
      o_div_update <= '0;
      // Set wins over a same-cycle clear.
      status_q     <= (status_q & ~status_clr) | i_status_evt;
      if (accept) begin
        if (wr_count_q != '1) wr_count_q <= wr_count_q + 1'b1;
        if (i_addr_bus == AddrStrobe) o_strobe <= i_data_write_bus;
        if (i_addr_bus == AddrCtrl && wr_ok) o_ctrl <= i_data_write_bus;
        for (int i = 0; i < N_CH; i++) begin
          if (i_addr_bus == ADDR_WIDTH'(AddrDivBase + i) && wr_ok) begin
            o_div[i*DATA_WIDTH +: DATA_WIDTH] <= i_data_write_bus;
            o_div_update[i]                   <= 1'b1;
          end
        end
      end
    end
  end

  // Read mux over current register values; write-side updates land a cycle later.
  always_comb begin
    rdata = '0;
    case (i_addr_bus)
      AddrId:      rdata = ID_VALUE;
      AddrCtrl:    rdata = o_ctrl;
      AddrStatus:  rdata = status_q;
      AddrWrCount: rdata = wr_count_q;
      AddrKey:     rdata = key_rdata;
      default: begin
        for (int i = 0; i < N_CH; i++) begin
          if (i_addr_bus == ADDR_WIDTH'(AddrDivBase + i)) rdata = o_div[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    endcase
  end

  // Registered read-back, one cycle after the address.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_data_read_bus <= '0;
    end else begin
      o_data_read_bus <= rdata;
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank (default parameters); covers the lock FSM when
// SPI_REG_BANK_LOCK_EN is defined.
module tb_spi_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  addr;
  logic [7:0]  wdata;
  logic        wr_en;
  logic [7:0]  rdata;
  logic [7:0]  evt;
  logic [7:0]  ctrl;
  logic [7:0]  strobe;
  logic [31:0] div;
  logic [3:0]  div_upd;

  int vectors     = 0;
  int miscompares = 0;
  int cnt         = 0;

  spi_reg_bank dut (
    .i_clk            (clk),
    .i_rst            (rst_n),
    .i_addr_bus       (addr),
    .i_data_write_bus (wdata),
    .i_wr_enable_bus  (wr_en),
    .o_data_read_bus  (rdata),
    .i_status_evt     (evt),
    .o_ctrl           (ctrl),
    .o_strobe         (strobe),
    .o_div            (div),
    .o_div_update     (div_upd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bump();
    if (cnt < 255) cnt++;
  endtask

  // Idle edge first so the enable is seen low, then one accepted write; returns #1 after accept.
  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    wr_en = 1'b0;
    tick();
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    bump();
  endtask

  task automatic rd(input logic [6:0] a, input logic [7:0] exp, input string tag);
    addr = a;
    tick();
    check(tag, {24'b0, rdata}, {24'b0, exp});
  endtask

  initial begin
    rst_n = 1'b0;
    addr  = '0;
    wdata = '0;
    wr_en = 1'b0;
    evt   = '0;
    tick();
    tick();
    check("rst_ctrl", {24'b0, ctrl}, 32'h0);
    check("rst_strobe", {24'b0, strobe}, 32'h0);
    check("rst_div", div, 32'h0);
    check("rst_rdata", {24'b0, rdata}, 32'h0);
    rst_n = 1'b1;
    rd(7'h00, 8'hC1, "id");
    rd(7'h10, 8'h00, "wrcnt_init");
    rd(7'h11, 8'h00, "key_init");

`ifdef SPI_REG_BANK_LOCK_EN
    wr(7'h01, 8'h55);
    check("locked_ctrl", {24'b0, ctrl}, 32'h0);
    wr(7'h11, 8'hA5);
    rd(7'h11, 8'h01, "key1_state");
    wr(7'h11, 8'h5A);
    rd(7'h11, 8'h02, "unlocked_state");
`endif

    // Enable held five cycles produces a single write.
    tick();
    addr  = 7'h01;
    wdata = 8'h3C;
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    wr_en = 1'b0;
    bump();
    check("held_ctrl", {24'b0, ctrl}, 32'h3C);
    rd(7'h10, 8'(cnt), "held_wrcnt");

    // Same-cycle read of the written address returns the old value.
    wr(7'h01, 8'h11);
    check("rd_old", {24'b0, rdata}, 32'h3C);
    rd(7'h01, 8'h11, "ctrl_new");

    wr(7'h02, 8'h81);
    check("strobe_pulse", {24'b0, strobe}, 32'h81);
    tick();
    check("strobe_clear", {24'b0, strobe}, 32'h0);
    rd(7'h02, 8'h00, "strobe_read");

    wr(7'h05, 8'h10);
    check("div1_val", div, 32'h0000_1000);
    check("div1_upd", {28'b0, div_upd}, 32'h2);
    tick();
    check("div1_upd_clear", {28'b0, div_upd}, 32'h0);
    wr(7'h07, 8'h77);
    check("div3_upd", {28'b0, div_upd}, 32'h8);
    check("div3_val", div, 32'h7700_1000);
    wr(7'h08, 8'h99);
    check("div_oob_upd", {28'b0, div_upd}, 32'h0);
    check("div_oob_val", div, 32'h7700_1000);
    rd(7'h08, 8'h00, "div_oob_read");
    rd(7'h05, 8'h10, "div1_read");

    evt = 8'h05;
    tick();
    evt = 8'h00;
    rd(7'h03, 8'h05, "status_set");
    // Clear bit0 while bit0 event fires: set wins.
    tick();
    addr  = 7'h03;
    wdata = 8'h01;
    wr_en = 1'b1;
    evt   = 8'h01;
    tick();
    wr_en = 1'b0;
    evt   = 8'h00;
    bump();
    rd(7'h03, 8'h05, "status_set_wins");
    wr(7'h03, 8'h04);
    rd(7'h03, 8'h01, "status_w1c_bit2");
    wr(7'h03, 8'h05);
    rd(7'h03, 8'h00, "status_w1c_all");

`ifdef SPI_REG_BANK_LOCK_EN
    wr(7'h11, 8'hA5);
    rd(7'h11, 8'h00, "relock");
    wr(7'h04, 8'h12);
    check("locked_div_upd", {28'b0, div_upd}, 32'h0);
    check("locked_div_val", div, 32'h7700_1000);
    wr(7'h11, 8'hA5);
    rd(7'h11, 8'h01, "key1_again");
    wr(7'h01, 8'h66);
    check("key1_abort_ctrl", {24'b0, ctrl}, 32'h11);
    rd(7'h11, 8'h00, "key1_abort_state");
`else
    wr(7'h11, 8'hA5);
    rd(7'h11, 8'h00, "key_nolock");
`endif
    rd(7'h10, 8'(cnt), "wrcnt_mid");

    // Reset during a pending write discards it.
    evt = 8'hFF;
    tick();
    evt   = 8'h00;
    rst_n = 1'b0;
    addr  = 7'h01;
    wdata = 8'hAA;
    wr_en = 1'b1;
    tick();
    tick();
    check("rst2_ctrl", {24'b0, ctrl}, 32'h0);
    check("rst2_div", div, 32'h0);
    check("rst2_upd", {28'b0, div_upd}, 32'h0);
    check("rst2_rdata", {24'b0, rdata}, 32'h0);
    wr_en = 1'b0;
    rst_n = 1'b1;
    cnt   = 0;
    tick();
    check("rst2_ctrl_after", {24'b0, ctrl}, 32'h0);
    rd(7'h03, 8'h00, "rst2_status");
    rd(7'h00, 8'hC1, "rst2_id");
    rd(7'h10, 8'h00, "rst2_wrcnt");
    rd(7'h11, 8'h00, "rst2_key");

    for (int i = 0; i < 300; i++) wr(7'h7F, 8'(i));
    rd(7'h10, 8'hFF, "wrcnt_sat");
    check("wrcnt_model", cnt, 32'd255);
    rd(7'h7F, 8'h00, "unmapped_read");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
